// File: rtl/oven_pkg.sv
// Shared types and default timing for the oven heat/timer setter front end.
package oven_pkg;

  localparam int unsigned CLK_HZ = 50000000;

  // Defaults derived from the 50 MHz system clock.
  localparam int unsigned DEBOUNCE_CYCLES_DEF = CLK_HZ / 100;  // 10 ms
  localparam int unsigned HOLD_DELAY_DEF      = CLK_HZ / 2;    // 0.5 s
  localparam int unsigned REPEAT_PERIOD_DEF   = CLK_HZ / 5;    // 0.2 s
  localparam int unsigned CNT_W_DEF           = 31;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HOLD_UP = 3'd1,
    RPT_UP  = 3'd2,
    HOLD_DN = 3'd3,
    RPT_DN  = 3'd4
  } btn_state_t;

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser plus consecutive-sample debounce for one active-low key.
module button_debounce
  import oven_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_n,
  output logic pressed
);

  logic             sync1_q;
  logic             sync2_q;
  logic             stable_q;
  logic             stable_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Stable level follows the synchronised level only after an unbroken run.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= btn_n;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign pressed = ~stable_q;

endmodule

// File: rtl/button_repeat_ctrl.sv
// Debounced up/down keys to single-cycle inc/dec pulses with hold-to-auto-repeat.
module button_repeat_ctrl
  import oven_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned HOLD_DELAY      = HOLD_DELAY_DEF,
  parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic button1,
  input  logic button2,
  output logic inc_pulse,
  output logic dec_pulse,
  output logic up_pressed,
  output logic down_pressed,
  output logic repeating
);

  btn_state_t       state_q;
  btn_state_t       state_d;
  logic [CNT_W-1:0] tmr_q;
  logic [CNT_W-1:0] tmr_d;
  logic             inc_q;
  logic             inc_d;
  logic             dec_q;
  logic             dec_d;
  logic             rpt_q;
  logic             rpt_d;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_deb_up (
    .clk    (clk),
    .reset_n(reset_n),
    .btn_n  (button1),
    .pressed(up_pressed)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_deb_dn (
    .clk    (clk),
    .reset_n(reset_n),
    .btn_n  (button2),
    .pressed(down_pressed)
  );

  // Release is checked first so it wins over a coinciding hold/repeat tick.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    inc_d   = 1'b0;
    dec_d   = 1'b0;
    case (state_q)
      IDLE: begin
        tmr_d = '0;
        if (up_pressed) begin
          inc_d   = 1'b1;
          state_d = HOLD_UP;
        end else if (down_pressed) begin
          dec_d   = 1'b1;
          state_d = HOLD_DN;
        end
      end
      HOLD_UP, RPT_UP: begin
        if (!up_pressed) begin
          state_d = IDLE;
          tmr_d   = '0;
        end else if ((state_q == HOLD_UP && tmr_q == CNT_W'(HOLD_DELAY - 1)) ||
                     (state_q == RPT_UP  && tmr_q == CNT_W'(REPEAT_PERIOD - 1))) begin
          inc_d   = 1'b1;
          state_d = RPT_UP;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + CNT_W'(1);
        end
      end
      HOLD_DN, RPT_DN: begin
        if (!down_pressed) begin
          state_d = IDLE;
          tmr_d   = '0;
        end else if ((state_q == HOLD_DN && tmr_q == CNT_W'(HOLD_DELAY - 1)) ||
                     (state_q == RPT_DN  && tmr_q == CNT_W'(REPEAT_PERIOD - 1))) begin
          dec_d   = 1'b1;
          state_d = RPT_DN;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tmr_d   = '0;
      end
    endcase
    rpt_d = (state_d == RPT_UP) || (state_d == RPT_DN);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
      rpt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      inc_q   <= inc_d;
      dec_q   <= dec_d;
      rpt_q   <= rpt_d;
    end
  end

  assign inc_pulse = inc_q;
  assign dec_pulse = dec_q;
  assign repeating = rpt_q;

endmodule

// File: tb/tb_button_repeat_ctrl.sv
// Randomised and directed bench for button_repeat_ctrl against a press-age reference model.
module tb_button_repeat_ctrl;

  localparam int DEB = 4;
  localparam int HLD = 10;
  localparam int RPT = 3;

  logic clk = 1'b0;
  logic reset_n;
  logic button1;
  logic button2;
  logic inc_pulse;
  logic dec_pulse;
  logic up_pressed;
  logic down_pressed;
  logic repeating;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  button_repeat_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .HOLD_DELAY     (HLD),
    .REPEAT_PERIOD  (RPT),
    .CNT_W          (8)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .button1     (button1),
    .button2     (button2),
    .inc_pulse   (inc_pulse),
    .dec_pulse   (dec_pulse),
    .up_pressed  (up_pressed),
    .down_pressed(down_pressed),
    .repeating   (repeating)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
    end
  endtask

  // Reference model: raw samples -> debounced level by run length,
  // then pulses derived from the age of the current press.
  bit m_ok = 1'b0;
  bit raw_hist[2][3];
  int nsamp;
  bit m_rel[2];
  int run[2];
  int act;   // 0 none, 1 up, 2 down
  int age;
  bit m_inc, m_dec, m_rpt;

  always @(posedge clk) begin
    bit x;
    cyc++;
    if (!reset_n) begin
      m_ok  = 1'b1;
      nsamp = 0;
      act   = 0;
      age   = 0;
      m_inc = 1'b0;
      m_dec = 1'b0;
      m_rpt = 1'b0;
      for (int b = 0; b < 2; b++) begin
        m_rel[b] = 1'b1;
        run[b]   = 0;
      end
    end else begin
      m_inc = 1'b0;
      m_dec = 1'b0;
      if (act == 0) begin
        age = 0;
        if (!m_rel[0]) begin act = 1; m_inc = 1'b1; end
        else if (!m_rel[1]) begin act = 2; m_dec = 1'b1; end
      end else if (m_rel[act-1]) begin
        act = 0;
        age = 0;
      end else begin
        age++;
        if (age == HLD || (age > HLD && (age - HLD) % RPT == 0)) begin
          if (act == 1) m_inc = 1'b1;
          else m_dec = 1'b1;
        end
      end
      m_rpt = (act != 0) && (age >= HLD);
      if (nsamp < 3) nsamp++;
      for (int b = 0; b < 2; b++) begin
        raw_hist[b][2] = raw_hist[b][1];
        raw_hist[b][1] = raw_hist[b][0];
        raw_hist[b][0] = (b == 0) ? button1 : button2;
        x = (nsamp >= 3) ? raw_hist[b][2] : 1'b1;
        if (x == m_rel[b]) begin
          run[b] = 0;
        end else begin
          run[b]++;
          if (run[b] == DEB) begin
            m_rel[b] = x;
            run[b]   = 0;
          end
        end
      end
    end
  end

  // Event logs used by the hand-computed scenario checks.
  int inc_log[$];
  int dec_log[$];
  int up_first;
  int rpt_first;

  always @(negedge clk) begin
    if (m_ok) begin
      check("inc_pulse", int'(inc_pulse), int'(m_inc));
      check("dec_pulse", int'(dec_pulse), int'(m_dec));
      check("up_pressed", int'(up_pressed), int'(!m_rel[0]));
      check("down_pressed", int'(down_pressed), int'(!m_rel[1]));
      check("repeating", int'(repeating), int'(m_rpt));
      check("pulse_excl", int'(inc_pulse & dec_pulse), 0);
      if (inc_pulse) inc_log.push_back(cyc);
      if (dec_pulse) dec_log.push_back(cyc);
      if (up_pressed && up_first < 0) up_first = cyc;
      if (repeating && rpt_first < 0) rpt_first = cyc;
    end
  end

  task automatic clear_logs();
    inc_log.delete();
    dec_log.delete();
    up_first  = -1;
    rpt_first = -1;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int rel(input int q[$], input int idx, input int base);
    if (idx < q.size()) return q[idx] - base;
    return -1;
  endfunction

  initial begin
    int c0;
    int r;
    int exp_rep[5];
    reset_n = 1'b0;
    button1 = 1'b1;
    button2 = 1'b1;
    clear_logs();
    wait_cyc(3);
    check("rst_inc", int'(inc_pulse), 0);
    check("rst_dec", int'(dec_pulse), 0);
    check("rst_up", int'(up_pressed), 0);
    check("rst_dn", int'(down_pressed), 0);
    check("rst_rpt", int'(repeating), 0);
    reset_n = 1'b1;
    wait_cyc(5);

    // Clean press
    clear_logs();
    c0 = cyc;
    button1 = 1'b0;
    wait_cyc(8);
    button1 = 1'b1;
    wait_cyc(15);
    check("clean_n_inc", inc_log.size(), 1);
    check("clean_inc_edge", rel(inc_log, 0, c0), 7);
    check("clean_n_dec", dec_log.size(), 0);
    check("clean_up_edge", (up_first < 0) ? -1 : up_first - c0, 6);

    // Bounce shorter than the debounce window
    clear_logs();
    for (int i = 0; i < 3; i++) begin
      button1 = 1'b0;
      wait_cyc(2);
      button1 = 1'b1;
      wait_cyc(2);
    end
    wait_cyc(15);
    check("bounce_n_inc", inc_log.size(), 0);
    check("bounce_up_seen", up_first, -1);

    // Auto-repeat on button2
    clear_logs();
    c0 = cyc;
    button2 = 1'b0;
    wait_cyc(40);
    button2 = 1'b1;
    wait_cyc(15);
    exp_rep = '{7, 17, 20, 23, 26};
    check("rpt_n_dec", dec_log.size(), 11);
    for (int i = 0; i < 5; i++) check("rpt_dec_edge", rel(dec_log, i, c0), exp_rep[i]);
    check("rpt_first", (rpt_first < 0) ? -1 : rpt_first - c0, 17);

    // Simultaneous press, then hand-over to button2
    clear_logs();
    c0 = cyc;
    button1 = 1'b0;
    button2 = 1'b0;
    wait_cyc(18);
    button1 = 1'b1;
    wait_cyc(20);
    button2 = 1'b1;
    wait_cyc(15);
    check("sim_n_inc", inc_log.size(), 4);
    check("sim_first_dec", rel(dec_log, 0, c0), 26);

    // Release that lands on a repeat tick
    clear_logs();
    c0 = cyc;
    button2 = 1'b0;
    wait_cyc(22);
    button2 = 1'b1;
    wait_cyc(15);
    check("tick_n_dec", dec_log.size(), 5);
    check("tick_last_dec", rel(dec_log, 4, c0), 26);

    // Reset while auto-repeating up
    clear_logs();
    button1 = 1'b0;
    wait_cyc(25);
    reset_n = 1'b0;
    wait_cyc(1);
    r = cyc;
    check("mid_rst_inc", int'(inc_pulse), 0);
    check("mid_rst_up", int'(up_pressed), 0);
    check("mid_rst_rpt", int'(repeating), 0);
    reset_n = 1'b1;
    clear_logs();
    wait_cyc(12);
    check("post_rst_inc_edge", rel(inc_log, 0, r), 7);
    button1 = 1'b1;
    wait_cyc(15);

    // Randomised key activity with occasional resets
    for (int s = 0; s < 80; s++) begin
      button1 = 1'($urandom_range(0, 1));
      button2 = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) begin
        reset_n = 1'b0;
        wait_cyc(1);
        reset_n = 1'b1;
      end
      wait_cyc(int'($urandom_range(1, 30)));
    end
    button1 = 1'b1;
    button2 = 1'b1;
    wait_cyc(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
